// File: rtl/serial_add_sub_stage_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encodings.
package serial_add_sub_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_sub_stage_full_adder_bit.sv
// One-bit full adder used as the serial datapath core.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sub_stage.sv
// Bit-serial two's-complement add/subtract with start/result handshakes.
// Operand B arrives already inverted upstream when subMode=1; subMode is the carry-in.
module serial_add_sub_stage
  import serial_add_sub_stage_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         resetN,
  input  logic         startValid,
  output logic         startReady,
  input  logic         subMode,
  input  logic [n-1:0] operandA,
  input  logic [n-1:0] operandB,
  output logic         resultValid,
  input  logic         resultReady,
  output logic [n-1:0] sum,
  output logic         carryOut,
  output logic         overflow,
  output logic         zero,
  output logic         busy
);

  localparam int CNT_W = $clog2(n + 1);

  state_t           state;
  logic [n-1:0]     shift_a;
  logic [n-1:0]     shift_b;
  logic [n-1:0]     sum_shift;
  logic             carry;
  logic [CNT_W-1:0] bit_cnt;

  logic             add_s;
  logic             add_c;
  logic [n:0]       sum_cat;
  logic [n-1:0]     sum_next;
  logic             last_bit;

  full_adder_bit u_fa (
    .a    (shift_a[0]),
    .b    (shift_b[0]),
    .cin  (carry),
    .s    (add_s),
    .cout (add_c)
  );

  // New sum bit enters at the MSB; concatenation keeps this legal for n=1.
  assign sum_cat  = {add_s, sum_shift};
  assign sum_next = sum_cat[n:1];
  assign last_bit = (bit_cnt == CNT_W'(n - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      startReady  <= 1'b1;
      busy        <= 1'b0;
      resultValid <= 1'b0;
      sum         <= '0;
      carryOut    <= 1'b0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      shift_a     <= '0;
      shift_b     <= '0;
      sum_shift   <= '0;
      carry       <= 1'b0;
      bit_cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (startValid) begin
            shift_a    <= operandA;
            shift_b    <= operandB;
            carry      <= subMode;
            bit_cnt    <= '0;
            startReady <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum_shift <= sum_next;
          shift_a   <= shift_a >> 1;
          shift_b   <= shift_b >> 1;
          carry     <= add_c;
          bit_cnt   <= bit_cnt + 1'b1;
          if (last_bit) begin
            // carry still holds the carry into the MSB during this add
            sum         <= sum_next;
            carryOut    <= add_c;
            overflow    <= carry ^ add_c;
            zero        <= (sum_next == '0);
            resultValid <= 1'b1;
            state       <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resultReady) begin
            resultValid <= 1'b0;
            startReady  <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          state      <= ST_IDLE;
          startReady <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
